// File: rtl/demux1to1024_reg_n_pkg.sv
// demux_pkg: shared geometry of the 1024-entry write demux (8 groups of 128).
package demux_pkg;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;
    localparam int GRP    = 8;
    localparam int GRP_W  = 3;
    localparam int SUB    = 128;
    localparam int SUB_W  = 7;

    function automatic logic [GRP-1:0] grp_dec(input logic [GRP_W-1:0] a);
        return GRP'(1) << a;
    endfunction
endpackage

// File: rtl/demux1to1024_reg_n_if.sv
// demux1to1024_reg_n_if: write port and entry readout of the 1024-entry demux.
// clr_i exists only when DEMUX_CLEAR_EN is defined.
interface demux1to1024_reg_n_if import demux_pkg::*; #(parameter int n = 4);
    logic              wr_en_i;
    logic [ADDR_W-1:0] addr_i;
    logic [n-1:0]      data_i;
    logic [n-1:0]      data_o [0:DEPTH-1];
    logic              wr_ack_o;
`ifdef DEMUX_CLEAR_EN
    logic              clr_i;
`endif
    modport master (
`ifdef DEMUX_CLEAR_EN
        output clr_i,
`endif
        output wr_en_i, addr_i, data_i,
        input  data_o, wr_ack_o
    );
    modport slave (
`ifdef DEMUX_CLEAR_EN
        input  clr_i,
`endif
        input  wr_en_i, addr_i, data_i,
        output data_o, wr_ack_o
    );
endinterface

// File: rtl/demux1to1024_reg_n_sub.sv
// demux1to128_n: in-group address decode and storage for 128 entries.
// With DEMUX_CLEAR_EN, a clear zeroes the group but a same-cycle write still lands.
module demux1to128_n import demux_pkg::*; #(parameter int n = 4) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_we,
    input  logic [SUB_W-1:0] i_sub,
    input  logic [n-1:0]     i_data,
`ifdef DEMUX_CLEAR_EN
    input  logic             i_clr,
`endif
    output logic [n-1:0]     o_ent [0:SUB-1]
);
    logic [SUB-1:0] w_sel;
    logic [n-1:0]   r_ent [0:SUB-1];

    always_comb w_sel = i_we ? (SUB'(1) << i_sub) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ent <= '{default: '0};
        end else begin
            for (int i = 0; i < SUB; i++) begin
                if (w_sel[i]) r_ent[i] <= i_data;
`ifdef DEMUX_CLEAR_EN
                else if (i_clr) r_ent[i] <= '0;
`endif
            end
        end
    end

    assign o_ent = r_ent;
endmodule

// File: rtl/demux1to1024_reg_n.sv
// demux1to1024_reg_n: two-stage registered 1:1024 write demux; stage 1 + group decode here.
// Optional DEMUX_CLEAR_EN adds clr_i, which zeroes every entry at stage 2.
module demux1to1024_reg_n import demux_pkg::*; #(parameter int n = 4) (
    input logic                 clk_i,
    input logic                 rst_ni,
    demux1to1024_reg_n_if.slave bus
);
    logic             r_vld;
    logic [GRP-1:0]   r_grp;
    logic [SUB_W-1:0] r_sub;
    logic [n-1:0]     r_data;
    logic             r_ack;
`ifdef DEMUX_CLEAR_EN
    logic             r_clr;
`endif
    logic [n-1:0]     w_ent [0:GRP-1][0:SUB-1];

    // Address and data only load on a write so idle-cycle garbage never reaches stage 2.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld  <= 1'b0;
            r_grp  <= '0;
            r_sub  <= '0;
            r_data <= '0;
            r_ack  <= 1'b0;
`ifdef DEMUX_CLEAR_EN
            r_clr  <= 1'b0;
`endif
        end else begin
            r_vld <= bus.wr_en_i;
            r_ack <= r_vld;
            if (bus.wr_en_i) begin
                r_grp  <= grp_dec(bus.addr_i[ADDR_W-1:SUB_W]);
                r_sub  <= bus.addr_i[SUB_W-1:0];
                r_data <= bus.data_i;
            end
`ifdef DEMUX_CLEAR_EN
            r_clr <= bus.clr_i;
`endif
        end
    end

    for (genvar g = 0; g < GRP; g++) begin : g_grp
        demux1to128_n #(.n(n)) u_grp (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .i_we   (r_vld & r_grp[g]),
            .i_sub  (r_sub),
            .i_data (r_data),
`ifdef DEMUX_CLEAR_EN
            .i_clr  (r_clr),
`endif
            .o_ent  (w_ent[g])
        );
        for (genvar e = 0; e < SUB; e++) begin : g_ent
            assign bus.data_o[g*SUB+e] = w_ent[g][e];
        end
    end

    assign bus.wr_ack_o = r_ack;
endmodule

// File: tb/tb_demux1to1024_reg_n.sv
// tb_demux1to1024_reg_n: scoreboard bench; each write queues its expected commit cycle and value.
module tb_demux1to1024_reg_n;
    typedef struct {
        int         due;
        logic [9:0] a;
        logic [3:0] d;
        bit         c;
    } item_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int cyc = 0;
    int n_chk = 0;
    int n_bad = 0;
    item_t sb[$];
    logic [3:0] exp_mem [0:1023];

    demux1to1024_reg_n_if #(.n(4)) bus();
    demux1to1024_reg_n #(.n(4)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 1024; i++) check($sformatf("%s[%0h]", tag, i), 32'(bus.data_o[i]), 32'(exp_mem[i]));
    endtask

    task automatic drive(input logic [9:0] a, input logic [3:0] d, input bit c, input bit push);
        bus.wr_en_i = 1'b1;
        bus.addr_i  = a;
        bus.data_i  = d;
`ifdef DEMUX_CLEAR_EN
        bus.clr_i   = c;
`endif
        if (push) sb.push_back('{cyc + 2, a, d, c});
    endtask

    task automatic wr(input logic [9:0] a, input logic [3:0] d, input bit c = 1'b0, input bit push = 1'b1);
        @(negedge clk_i);
        drive(a, d, c, push);
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk_i);
            bus.wr_en_i = 1'b0;
            bus.addr_i  = 10'($urandom);
            bus.data_i  = 4'($urandom);
`ifdef DEMUX_CLEAR_EN
            bus.clr_i   = 1'b0;
`endif
        end
    endtask

    // Monitor: every ack must match the oldest pending write's commit cycle and value.
    initial forever begin
        item_t it;
        @(posedge clk_i);
        #1;
        if (bus.wr_ack_o) begin
            if (sb.size() == 0) check("ack_spurious", 32'(bus.wr_ack_o), 0);
            else begin
                it = sb.pop_front();
                check("ack_time", cyc, it.due);
                if (it.c) exp_mem = '{default: '0};
                exp_mem[it.a] = it.d;
                check($sformatf("ack_data[%0h]", it.a), 32'(bus.data_o[it.a]), 32'(it.d));
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            it = sb.pop_front();
            check($sformatf("ack_missing[%0h]", it.a), 32'(bus.wr_ack_o), 1);
        end
    end

    initial begin
        exp_mem = '{default: '0};
        bus.wr_en_i = 1'b0;
        bus.addr_i  = '0;
        bus.data_i  = '0;
`ifdef DEMUX_CLEAR_EN
        bus.clr_i   = 1'b0;
`endif
        repeat (3) @(negedge clk_i);
        check("rst_ack", 32'(bus.wr_ack_o), 0);
        check_mem("rst_mem");
        // First write rides the very first edge after release.
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(10'h000, 4'h5, 1'b0, 1'b1);
        idle(3);
        check("w0_entry", 32'(bus.data_o[0]), 5);
        check_mem("w0_mem");
        wr(10'h07F, 4'h1);
        wr(10'h080, 4'h2);
        wr(10'h3FF, 4'hF);
        idle(3);
        check_mem("bound_mem");
        wr(10'h200, 4'h3);
        wr(10'h200, 4'hA);
        idle(3);
        check("b2b_entry", 32'(bus.data_o[10'h200]), 4'hA);
        check_mem("b2b_mem");
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) idle(1);
            else wr(10'($urandom), 4'($urandom));
        end
        idle(3);
        check_mem("rand_mem");
        idle(100);
        check_mem("idle_mem");
`ifdef DEMUX_CLEAR_EN
        wr(10'h010, 4'h9);
        wr(10'h020, 4'h4);
        wr(10'h020, 4'hC, 1'b1);
        wr(10'h030, 4'h5);
        idle(3);
        check("clr_010", 32'(bus.data_o[10'h010]), 0);
        check("clr_020", 32'(bus.data_o[10'h020]), 4'hC);
        check_mem("clr_mem");
`endif
        // Pending write is killed by an asynchronous reset before its commit edge.
        wr(10'h155, 4'h7, 1'b0, 1'b0);
        @(negedge clk_i);
        bus.wr_en_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        exp_mem = '{default: '0};
        check("arst_ack", 32'(bus.wr_ack_o), 0);
        check("arst_155", 32'(bus.data_o[10'h155]), 0);
        check_mem("arst_mem");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        idle(3);
        check("arst_155_after", 32'(bus.data_o[10'h155]), 0);
        wr(10'h155, 4'h6);
        idle(3);
        check_mem("post_rst_mem");
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
